melody_player: RTL
==================

# melody_player

Parametrised, table-driven melody sequencer for the smartphone audio path. It replaces per-song hard-coded state machines with a loadable note RAM. Each entry holds a tone half-period, a duration and a display name. The block steps through the entries on a start trigger, drives the square-wave `speaker` line and the 32-bit ASCII `note` bus, and supports rests, a configurable inter-note gap, looping and abort.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz; documentation only.
- `DEPTH`, 16: note-table entries; power of two; `AW = $clog2(DEPTH)`.
- `DIV_W`, 18: half-period width in clock cycles.
- `DUR_W`, 8: duration field width, in ticks.
- `TICK_CYCLES`, 1_000_000: cycles per duration tick (10 ms at 100 MHz).
- `GAP_TICKS`, 10: silent ticks after every entry; 0 means no gap.
- `SONG_ID`, 4: `song_state` value that arms the start trigger.

Ports:
- `basys_clock`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button`  in  1  start request; level input, rising edge detected internally.
- `song_state`  in  4  app song selector.
- `stop`  in  1  synchronous abort.
- `loop_en`  in  1  replay from entry 0 instead of finishing.
- `wr_en`  in  1  note-table write strobe.
- `wr_addr`  in  AW  entry address.
- `wr_half`  in  DIV_W  half-period in cycles; 0 = rest.
- `wr_dur`  in  DUR_W  duration in ticks; 0 = end-of-song marker.
- `wr_name`  in  32  ASCII note name.
- `speaker`  out  1  square wave.
- `note`  out  32  ASCII name of the sounding entry; 0 when silent.
- `busy`  out  1  high in TONE/GAP.
- `idx`  out  AW  current entry index.
- `done`  out  1  one-cycle pulse when the song completes normally.

## Operation
- Reset (async assert, sync deassert) sets state IDLE and clears `speaker`, `note`, `busy`, `idx`, `done`, the edge register and all counters. The note RAM is not reset; its contents persist across `rst_n`.
- RAM: one write port, written on `wr_en` in any state; asynchronous read at `idx`.
- States:
  - **IDLE**
    - Start condition: `button` high, previous `button` low, and `song_state == SONG_ID`.
    - On start, `idx` is set to 0. If entry 0 has dur == 0, go to DONE; otherwise latch the entry and go to TONE.
  - **TONE**
    - The latched entry plays for exactly dur×TICK_CYCLES cycles.
    - When half != 0:
      - A half-period counter toggles `speaker` each time it reaches half−1, then resets.
      - `speaker` starts at 0 on entry.
      - `note` = latched name.
    - When half == 0 (rest): `speaker` = 0 and `note` = 0.
    - At the end of the duration, go to GAP, or straight to ADVANCE logic if GAP_TICKS == 0.
  - **GAP**: `speaker` = 0 and `note` = 0 for GAP_TICKS×TICK_CYCLES cycles.
  - **Advance**
    - The song ends when `idx == DEPTH-1` or the next entry has dur == 0.
    - If the song ends and `loop_en` is high, set `idx` to 0 and enter TONE, unless entry 0 has dur == 0, which goes to DONE. If the song ends and `loop_en` is low, go to DONE.
    - Otherwise increment `idx`, latch the entry and enter TONE.
  - **DONE**: `done` = 1 for one cycle, then IDLE.
- `stop` has priority over everything except reset. In any state it forces IDLE on the next edge: `speaker`, `note`, `busy` go to 0, `idx` goes to 0, and `done` is not pulsed.
- `button` edges and `song_state` changes while busy are ignored.
- Entry fields are latched on TONE entry. A write to the playing address affects only later plays of that entry.
- Counters: tick counter counts 0..TICK_CYCLES−1; duration counter DUR_W bits; half counter DIV_W bits. There is no overflow, because comparisons are against latched values.

## Timing
- Start latency: the rising edge of `button` is seen at clock edge N. State becomes TONE and `busy`/`note` are valid after edge N+1.
- All outputs are registered.
- The first `speaker` toggle occurs half cycles after TONE entry, giving a square-wave period of 2×half cycles.
- TONE→GAP→next TONE spacing is exactly (dur+GAP_TICKS)×TICK_CYCLES cycles. Advance adds no extra cycle.
- `done` is asserted one cycle after the last GAP ends. `busy` drops in the same cycle `done` is high.
- `stop` and `button` rising on the same edge: `stop` wins and the block stays IDLE.

## Test plan
Parameters for all scenarios: TICK_CYCLES=10, GAP_TICKS=2, DEPTH=4, SONG_ID=4.

1. **Basic song.** Load {3,2,"cH"}, {0,1,0}, {x,0,x}; pulse `button` with `song_state`=4.
   - 20 cycles of TONE with `speaker` period 6 and `note`="cH".
   - 20 cycles silent gap, then a 10-cycle rest, then a 20-cycle gap.
   - `done` pulses once and `busy` returns to 0.
2. **Wrong selector.** `song_state`=3 with a `button` pulse → stays IDLE, `busy`=0, `speaker`=0.
3. **Loop.** `loop_en`=1 with four valid entries → after entry 3's gap, `idx` returns to 0 with no `done` pulse. Clearing `loop_en` mid-song ends after entry 3 with `done`.
4. **Stop mid-tone.** `stop` during entry 1 TONE → next cycle `speaker`=0, `note`=0, `busy`=0, `idx`=0, and `done` never pulses.
5. **Reset mid-play.** `rst_n` low mid-TONE → all outputs 0 asynchronously. After release, a `button` pulse replays the song with the table intact.
6. **Write during play.** Write entry 0 name "dH" during entry 0 TONE → `note` stays "cH" for the current play. The next loop pass shows "dH".

Source files
------------

// File: rtl/melody_player.sv
// melody_player: table-driven melody sequencer driving a square-wave speaker and an ASCII note bus
// Ports: basys_clock/rst_n clock and async active-low reset; button/song_state start trigger;
//        stop abort; loop_en replay; wr_* note-table write port; speaker/note/busy/idx/done outputs.
module melody_player #(
    parameter int         CLK_FREQ    = 100_000_000,
    parameter int         DEPTH       = 16,
    parameter int         DIV_W       = 18,
    parameter int         DUR_W       = 8,
    parameter int         TICK_CYCLES = 1_000_000,
    parameter int         GAP_TICKS   = 10,
    parameter logic [3:0] SONG_ID     = 4'd4,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic             basys_clock,
    input  logic             rst_n,
    input  logic             button,
    input  logic [3:0]       song_state,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DIV_W-1:0] wr_half,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [31:0]      wr_name,
    output logic             speaker,
    output logic [31:0]      note,
    output logic             busy,
    output logic [AW-1:0]    idx,
    output logic             done
);
    localparam int  TW      = $clog2(TICK_CYCLES + 1);
    localparam int  GW      = $clog2(GAP_TICKS + 1);
    localparam int  CW      = DUR_W > GW ? DUR_W : GW;
    localparam bit  HAS_GAP = GAP_TICKS != 0;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLK_FREQ <= 0 || TICK_CYCLES < 1) begin : g_param_check
        $error("melody_player: invalid parameters");
    end

    typedef enum logic [1:0] {IDLE, TONE, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] mem_half [DEPTH];
    logic [DUR_W-1:0] mem_dur  [DEPTH];
    logic [31:0]      mem_name [DEPTH];
    logic             btn_q, start_q, start_n;
    logic [AW-1:0]    idx_n, nidx;
    logic [TW-1:0]    tick, tick_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [DIV_W-1:0] hcnt, hcnt_n, lat_half, lat_half_n;
    logic [DUR_W-1:0] lat_dur, lat_dur_n;
    logic [31:0]      lat_name, lat_name_n, note_n;
    logic             speaker_n, busy_n, done_n;
    logic             tick_end, tone_end, gap_end, adv, song_end, half_wrap, load;

    // Note RAM is deliberately outside the reset domain so a loaded song survives rst_n.
    always_ff @(posedge basys_clock) begin
        if (wr_en) begin
            mem_half[wr_addr] <= wr_half;
            mem_dur[wr_addr]  <= wr_dur;
            mem_name[wr_addr] <= wr_name;
        end
    end

    assign tick_end  = tick == TW'(TICK_CYCLES - 1);
    assign tone_end  = state == TONE && tick_end && cnt == CW'(lat_dur) - 1'b1;
    assign gap_end   = state == GAP && tick_end && cnt == CW'(GAP_TICKS - 1);
    assign adv       = HAS_GAP ? gap_end : tone_end;
    assign song_end  = idx == AW'(DEPTH - 1) || mem_dur[idx + 1'b1] == '0;
    assign half_wrap = hcnt == lat_half - 1'b1;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        nidx       = '0;
        load       = 1'b0;
        tick_n     = '0;
        cnt_n      = '0;
        hcnt_n     = '0;
        lat_half_n = lat_half;
        lat_dur_n  = lat_dur;
        lat_name_n = lat_name;
        speaker_n  = 1'b0;
        note_n     = '0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        // The start edge is registered, so TONE is entered one edge after the button edge is seen.
        start_n    = state == IDLE && button && !btn_q && song_state == SONG_ID;
        case (state)
            IDLE: begin
                if (start_q) begin
                    idx_n = '0;
                    if (mem_dur[0] == '0) state_n = DONE;
                    else load = 1'b1;
                end
            end
            TONE, GAP: begin
                busy_n = 1'b1;
                tick_n = tick_end ? '0 : tick + 1'b1;
                cnt_n  = tick_end ? cnt + 1'b1 : cnt;
                if (state == TONE && lat_half != '0) begin
                    hcnt_n    = half_wrap ? '0 : hcnt + 1'b1;
                    speaker_n = speaker ^ half_wrap;
                    note_n    = lat_name;
                end
                // Advance happens on the last cycle of the entry so the next TONE starts with no bubble.
                if (adv) begin
                    if (!song_end) begin
                        load = 1'b1;
                        nidx = idx + 1'b1;
                    end else if (loop_en && mem_dur[0] != '0) load = 1'b1;
                    else state_n = DONE;
                end else if (tone_end) begin
                    state_n   = GAP;
                    tick_n    = '0;
                    cnt_n     = '0;
                    hcnt_n    = '0;
                    speaker_n = 1'b0;
                    note_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n    = TONE;
            idx_n      = nidx;
            lat_half_n = mem_half[nidx];
            lat_dur_n  = mem_dur[nidx];
            lat_name_n = mem_name[nidx];
            tick_n     = '0;
            cnt_n      = '0;
            hcnt_n     = '0;
            speaker_n  = 1'b0;
            busy_n     = 1'b1;
            note_n     = mem_half[nidx] != '0 ? mem_name[nidx] : '0;
        end
        if (state_n == DONE) begin
            done_n    = 1'b1;
            busy_n    = 1'b0;
            speaker_n = 1'b0;
            note_n    = '0;
        end
        if (stop) begin
            state_n   = IDLE;
            idx_n     = '0;
            tick_n    = '0;
            cnt_n     = '0;
            hcnt_n    = '0;
            speaker_n = 1'b0;
            note_n    = '0;
            busy_n    = 1'b0;
            done_n    = 1'b0;
            start_n   = 1'b0;
        end
    end

    always_ff @(posedge basys_clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            btn_q    <= 1'b0;
            start_q  <= 1'b0;
            idx      <= '0;
            tick     <= '0;
            cnt      <= '0;
            hcnt     <= '0;
            lat_half <= '0;
            lat_dur  <= '0;
            lat_name <= '0;
            speaker  <= 1'b0;
            note     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            btn_q    <= button;
            start_q  <= start_n;
            idx      <= idx_n;
            tick     <= tick_n;
            cnt      <= cnt_n;
            hcnt     <= hcnt_n;
            lat_half <= lat_half_n;
            lat_dur  <= lat_dur_n;
            lat_name <= lat_name_n;
            speaker  <= speaker_n;
            note     <= note_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end
endmodule
